// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg : shared types and defaults for the unified memory arbiter
// Revision     : 1.0
// ============================================================================
package mips_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_IF   = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mips_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mips_mem_arbiter_if : requester, memory-macro and halt signals of the arbiter
// Revision            : 1.0
// ============================================================================
interface mips_mem_arbiter_if #(
  parameter int AW = mips_mem_pkg::AW_DEF,
  parameter int DW = mips_mem_pkg::DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          halt_req;
  logic          halt_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata, halt_req,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid,
           rd_data, mem_en, mem_we, mem_addr, mem_wdata, halt_ack
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata, halt_req,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid,
           rd_data, mem_en, mem_we, mem_addr, mem_wdata, halt_ack
  );
endinterface
`default_nettype wire

// File: rtl/mips_mem_arbiter_sel.sv
`default_nettype none
// ============================================================================
// mem_arb_sel : combinational priority selector, req bit 0=LD, 1=DM, 2=IF
// Revision    : 1.0
// ============================================================================
module mem_arb_sel
  import mips_mem_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic       i_boost,
  input  state_e     i_state,
  output logic [2:0] o_gnt,
  output req_id_e    o_winner
);

  always_comb begin
    o_gnt    = 3'b000;
    o_winner = REQ_NONE;
    // LD always wins; the boost only lets a starved IF jump ahead of DM
    if (i_req[0]) begin
      o_gnt    = 3'b001;
      o_winner = REQ_LD;
    end else if (i_state == ST_RUN) begin
      if (i_req[2] && i_boost) begin
        o_gnt    = 3'b100;
        o_winner = REQ_IF;
      end else if (i_req[1]) begin
        o_gnt    = 3'b010;
        o_winner = REQ_DM;
      end else if (i_req[2]) begin
        o_gnt    = 3'b100;
        o_winner = REQ_IF;
      end
    end else if (i_state == ST_DRAIN && i_req[1]) begin
      o_gnt    = 3'b010;
      o_winner = REQ_DM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// mips_mem_arbiter : LD/DM/IF arbiter for the single-port unified memory,
//                    with IF anti-starvation and drain/halt sequencing
// Revision         : 1.0
// ============================================================================
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk1,
  input  logic                rst,
  mips_mem_arbiter_if.slave   bus
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  req_id_e       tag_q, tag_d;

  logic [2:0]    w_req;
  logic [2:0]    w_gnt;
  req_id_e       w_winner;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_is_read;

  // Requests are masked while reset is held so no grant leaks out
  assign w_req = rst ? 3'b000 : {bus.if_req, bus.dm_req, bus.ld_req};

  mem_arb_sel u_sel (
    .i_req    (w_req),
    .i_boost  (starve_cnt_q == C_STARVE_MAX),
    .i_state  (state_q),
    .o_gnt    (w_gnt),
    .o_winner (w_winner)
  );

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    unique case (w_winner)
      REQ_LD: begin
        w_mem_we    = bus.ld_we;
        w_mem_addr  = bus.ld_addr;
        w_mem_wdata = bus.ld_wdata;
      end
      REQ_DM: begin
        w_mem_we    = bus.dm_we;
        w_mem_addr  = bus.dm_addr;
        w_mem_wdata = bus.dm_wdata;
      end
      REQ_IF:  w_mem_addr = bus.if_addr;
      default: ;
    endcase
  end

  assign w_is_read = (w_winner != REQ_NONE) && !w_mem_we;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tag_d        = w_is_read ? w_winner : REQ_NONE;
    unique case (state_q)
      ST_RUN:    if (bus.halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.halt_req)                         state_d = ST_RUN;
        else if (!bus.dm_req && tag_d == REQ_NONE) state_d = ST_HALTED;
      end
      ST_HALTED: if (!bus.halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    // The counter is frozen while draining so a resumed RUN keeps its history
    if (state_q != ST_DRAIN) begin
      if (bus.if_req && !w_gnt[2]) begin
        if (starve_cnt_q != C_STARVE_MAX) starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      starve_cnt_q <= 4'd0;
      tag_q        <= REQ_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.ld_gnt    = w_gnt[0];
  assign bus.dm_gnt    = w_gnt[1];
  assign bus.if_gnt    = w_gnt[2];
  assign bus.ld_rvalid = (tag_q == REQ_LD);
  assign bus.dm_rvalid = (tag_q == REQ_DM);
  assign bus.if_rvalid = (tag_q == REQ_IF);
  assign bus.rd_data   = (tag_q != REQ_NONE) ? bus.mem_rdata : '0;
  assign bus.mem_en    = |w_gnt;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.halt_ack  = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mips_mem_arbiter : scoreboard bench for the unified memory arbiter
// Revision            : 1.0
// ============================================================================
module tb_mips_mem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mips_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  // Memory macro: one-cycle read latency
  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] shadow [0:1023];
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // Requester intent and reference-model state (0=RUN 1=DRAIN 2=HALTED)
  logic          ld_pend = 0, ld_we_v = 0, dm_pend = 0, dm_we_v = 0, if_pend = 0, halt_v = 0;
  logic [AW-1:0] ld_addr_v = '0, dm_addr_v = '0, if_addr_v = '0;
  logic [DW-1:0] ld_wdata_v = '0, dm_wdata_v = '0;
  int            mst = 0, starve = 0, last_w = 0;
  logic [2:0]    obs_rv;
  logic [DW-1:0] obs_rd;
  logic          obs_ack;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk1) begin
    if (!rst) begin
      logic [2:0] rv;
      rv = {bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("rvalid", 64'(rv), 64'(3'b001 << (exp_q[0].id - 1)));
        check("rd_data", 64'(bus.rd_data), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        check("no_rvalid", 64'(rv), 64'd0);
      end
    end
  end

  task automatic drive();
    bus.ld_req = ld_pend; bus.ld_we = ld_we_v; bus.ld_addr = ld_addr_v; bus.ld_wdata = ld_wdata_v;
    bus.dm_req = dm_pend; bus.dm_we = dm_we_v; bus.dm_addr = dm_addr_v; bus.dm_wdata = dm_wdata_v;
    bus.if_req = if_pend; bus.if_addr = if_addr_v; bus.halt_req = halt_v;
  endtask

  // One clock: drive intent, predict winner from the rules, compare, advance model
  task automatic cycle();
    int            w;
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    logic [63:0]   mact, mexp;
    drive();
    @(negedge clk1);
    w = 0;
    if (ld_pend) w = 1;
    else if (mst == 0) begin
      if (if_pend && starve == LIMIT) w = 3;
      else if (dm_pend)               w = 2;
      else if (if_pend)               w = 3;
    end else if (mst == 1 && dm_pend) w = 2;
    check("gnt", 64'({bus.if_gnt, bus.dm_gnt, bus.ld_gnt}), (w == 0) ? 64'd0 : 64'(3'b001 << (w - 1)));
    check("halt_ack", 64'(bus.halt_ack), 64'(mst == 2));
    we = (w == 1) ? ld_we_v : (w == 2) ? dm_we_v : 1'b0;
    a  = (w == 1) ? ld_addr_v : (w == 2) ? dm_addr_v : if_addr_v;
    wd = (w == 1) ? ld_wdata_v : dm_wdata_v;
    mact = bus.mem_en ? {20'd0, 1'b1, bus.mem_we, bus.mem_addr, (bus.mem_we ? bus.mem_wdata : 32'd0)}
                      : {20'd0, 1'b0, 43'd0};
    mexp = (w != 0) ? {20'd0, 1'b1, we, a, (we ? wd : 32'd0)} : 64'd0;
    check("mem_port", mact, mexp);
    rd = (w != 0) && !we;
    if (rd) exp_q.push_back('{w, shadow[a], cyc + 1});
    if (w != 0 && we) shadow[a] = wd;
    obs_rv  = {bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid};
    obs_rd  = bus.rd_data;
    obs_ack = bus.halt_ack;
    last_w  = w;
    if (mst != 1) starve = (if_pend && w != 3) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    case (mst)
      0: if (halt_v) mst = 1;
      1: if (!halt_v) mst = 0; else if (!dm_pend && !rd) mst = 2;
      default: if (!halt_v) mst = 0;
    endcase
    if (w == 1) ld_pend = 0;
    if (w == 2) dm_pend = 0;
    if (w == 3) if_pend = 0;
    @(posedge clk1); #1;
  endtask

  task automatic rand_fill(input int pl, input int pd, input int pi);
    if (!ld_pend && $urandom_range(99) < pl) begin
      ld_pend = 1; ld_we_v = 1'($urandom_range(1)); ld_addr_v = AW'($urandom_range(15)); ld_wdata_v = $urandom;
    end
    if (!dm_pend && $urandom_range(99) < pd) begin
      dm_pend = 1; dm_we_v = 1'($urandom_range(1)); dm_addr_v = AW'($urandom_range(15)); dm_wdata_v = $urandom;
    end
    if (!if_pend && $urandom_range(99) < pi) begin
      if_pend = 1; if_addr_v = AW'($urandom_range(15));
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_gnt_rv"}, 64'({bus.if_gnt, bus.dm_gnt, bus.ld_gnt, bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid}), 64'd0);
    check({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
    check({tag, "_mem_ctl"}, 64'({bus.mem_en, bus.mem_we, bus.halt_ack}), 64'd0);
  endtask

  initial begin
    int n, w1, w2, w3;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    mem[3] = 32'h0ce77800; shadow[3] = 32'h0ce77800;
    drive();
    @(negedge clk1);
    reset_checks("reset");
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;

    // Single IF read
    if_pend = 1; if_addr_v = 10'h003;
    cycle();
    check("t1_winner", 64'(last_w), 64'd3);
    cycle();
    check("t1_rvalid", 64'(obs_rv), 64'b100);
    check("t1_data", 64'(obs_rd), 64'h0ce77800);

    // All three in the same cycle
    ld_pend = 1; ld_we_v = 0; ld_addr_v = 10'd1;
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 10'd2;
    if_pend = 1; if_addr_v = 10'd4;
    cycle(); w1 = last_w;
    cycle(); w2 = last_w;
    cycle(); w3 = last_w;
    check("order", 64'({w1[3:0], w2[3:0], w3[3:0]}), 64'h123);
    cycle();

    // IF starvation under continuous DM traffic
    if_pend = 1; if_addr_v = 10'd5; n = 0;
    do begin
      dm_pend = 1; dm_we_v = 0; dm_addr_v = AW'($urandom_range(15));
      cycle(); n++;
    end while (last_w != 3 && n < 20);
    check("starve_grant_cycle", 64'(n), 64'd5);
    dm_pend = 1; if_pend = 1;
    cycle();
    check("starve_cleared", 64'(last_w), 64'd2);
    cycle();
    cycle();

    // Halt with a DM read in flight
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 10'd6;
    if_pend = 1; if_addr_v = 10'd7; halt_v = 1;
    n = 0;
    do begin cycle(); n++; end while (!obs_ack && n < 10);
    check("halt_ack_seen", 64'(obs_ack), 64'd1);
    ld_pend = 1; ld_we_v = 1; ld_addr_v = 10'd8; ld_wdata_v = 32'hFC000000;
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 10'd8;
    cycle();
    check("halted_ld_write", 64'(last_w), 64'd1);
    cycle();
    check("halted_dm_held", 64'(last_w), 64'd0);

    // Release halt: IF first, then DM sees the loader data
    halt_v = 0;
    cycle();
    check("release_ack_same_cycle", 64'(obs_ack), 64'd1);
    cycle();
    check("release_ack_dropped", 64'(obs_ack), 64'd0);
    check("release_if_first", 64'(last_w), 64'd3);
    cycle();
    check("release_dm_next", 64'(last_w), 64'd2);
    cycle();
    check("dm_reads_ld_data", 64'(obs_rd), 64'hFC000000);

    // Reset in the cycle after a DM read grant
    dm_pend = 1; dm_we_v = 0; dm_addr_v = 10'd9;
    cycle();
    check("pre_reset_dm", 64'(last_w), 64'd2);
    rst = 1'b1;
    exp_q.delete();
    if_pend = 1; if_addr_v = 10'd10;
    drive();
    @(negedge clk1);
    reset_checks("mid_reset");
    @(posedge clk1);
    #1 rst = 1'b0;
    mst = 0; starve = 0;
    cycle();
    check("post_reset_if", 64'(last_w), 64'd3);

    // Randomised traffic with halt toggling
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(39) == 0) halt_v = ~halt_v;
      rand_fill(25, 40, 50);
      cycle();
    end
    halt_v = 0;
    repeat (20) cycle();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
